contact_writeback: RTL

Downstream collector for the sphere-collision core. On each rising edge of the core's `done`, it samples the `ret` flag and the seven contact fields: cx, cy, cz, normalx, normaly, normalz and depth. Records with a contact (`ret`=1) are buffered in a small FIFO and serialised as 7 consecutive word writes into the 7-field result memory. Running pair and contact counts and capacity/overflow flags are exposed for the JTAG/debug readout.

---
 rtl/contact_writeback.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/contact_writeback.sv
// Collects contact records from the sphere-collision core, queues them and writes
// each one as seven consecutive words into the result memory.
module contact_writeback #(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_WORDS  = 35,
    parameter int REC_WORDS  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done,
    input  logic        ret,
    input  logic [31:0] cx,
    input  logic [31:0] cy,
    input  logic [31:0] cz,
    input  logic [31:0] normalx,
    input  logic [31:0] normaly,
    input  logic [31:0] normalz,
    input  logic [31:0] depth,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_we,
    output logic        mem_cs,
    output logic [15:0] pair_count,
    output logic [15:0] contact_count,
    output logic        full,
    output logic        overflow,
    output logic        busy
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CAP     = MEM_WORDS / REC_WORDS;
    localparam logic [2:0]  LAST_K  = 3'(REC_WORDS - 1);
    localparam logic [AW:0] DEPTH_N = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] CAP_N   = 16'(CAP);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;
    state_t state, state_nxt;

    logic          done_d;
    logic          ev, push, pop, fifo_empty, fifo_full;
    logic [223:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic [223:0]  hold, head, src;
    logic [2:0]    k, k_nxt;
    logic [31:0]   base, base_nxt;
    logic          we_nxt;
    logic [31:0]   addr_nxt, data_nxt;

    assign ev         = done & ~done_d;
    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == DEPTH_N);
    assign push       = ev & ret & ~fifo_full & ~full;
    assign head       = fifo_mem[rd_ptr];
    assign mem_cs     = mem_we;
    assign busy       = ~fifo_empty | (state != IDLE);

    // Event detection, counters and capacity/overflow flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_d        <= 1'b0;
            pair_count    <= '0;
            contact_count <= '0;
            full          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            done_d <= done;
            if (ev) begin
                pair_count <= pair_count + 16'd1;
                if (push) begin
                    contact_count <= contact_count + 16'd1;
                    full          <= (contact_count + 16'd1 == CAP_N);
                end else if (ret) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {depth, normalz, normaly, normalx, cz, cy, cx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = WRITE;
            WRITE:   if (k == LAST_K && fifo_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // k names the word being presented; the next record starts on the edge after word 6
    always_comb begin
        pop      = 1'b0;
        k_nxt    = k;
        base_nxt = base;
        we_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    k_nxt  = 3'd0;
                    we_nxt = 1'b1;
                end
            end
            WRITE: begin
                if (k == LAST_K) begin
                    base_nxt = base + 32'd7;
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        k_nxt  = 3'd0;
                        we_nxt = 1'b1;
                    end
                end else begin
                    k_nxt  = k + 3'd1;
                    we_nxt = 1'b1;
                end
            end
            default: ;
        endcase
        src      = pop ? head : hold;
        addr_nxt = we_nxt ? base_nxt + {29'd0, k_nxt} : 32'd0;
        data_nxt = we_nxt ? src[{k_nxt, 5'b0} +: 32] : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            base     <= '0;
            hold     <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            k        <= k_nxt;
            base     <= base_nxt;
            mem_we   <= we_nxt;
            mem_addr <= addr_nxt;
            mem_data <= data_nxt;
            if (pop) hold <= head;
        end
    end
endmodule
